// File: rtl/fetch_dec_queue.sv
// Fetch-to-decode instruction buffer: DEPTH-entry in-order FIFO with valid/ready
// on both sides, one-cycle flush on kill, and all-zero bubble fields when empty.
module fetch_dec_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int EXC_W = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     kill_i,
  input  logic                     fetch_valid_i,
  output logic                     fetch_ready_o,
  input  logic [XLEN-1:0]          fetch_instr_i,
  input  logic [XLEN-1:0]          fetch_pc_i,
  input  logic [XLEN-1:0]          fetch_pred_pc_i,
  input  logic                     fetch_prediction_i,
  input  logic                     fetch_taken_i,
  input  logic                     fetch_misaligned_instr_exc_i,
  input  logic                     fetch_instr_fault_exc_i,
  output logic                     dec_valid_o,
  input  logic                     dec_ready_i,
  output logic [XLEN-1:0]          dec_instr_o,
  output logic [XLEN-1:0]          dec_pc_o,
  output logic [XLEN-1:0]          dec_pred_pc_o,
  output logic                     dec_prediction_o,
  output logic                     dec_taken_o,
  output logic [EXC_W-1:0]         dec_exc_bits_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0]  instr;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pred_pc;
    logic             prediction;
    logic             taken;
    logic [EXC_W-1:0] exc;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        push_entry;
  entry_t        head;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  logic          pop;

  // Full/empty come from the occupancy count only, so pointer equality is never ambiguous.
  assign fetch_ready_o = (count_q != FULL_COUNT);
  assign dec_valid_o   = (count_q != '0);
  assign count_o       = count_q;
  assign push          = fetch_valid_i && fetch_ready_o;
  assign pop           = dec_valid_o && dec_ready_i;

  // Exception bits are packed into their architectural positions as the entry is stored.
  always_comb begin
    push_entry            = '0;
    push_entry.instr      = fetch_instr_i;
    push_entry.pc         = fetch_pc_i;
    push_entry.pred_pc    = fetch_pred_pc_i;
    push_entry.prediction = fetch_prediction_i;
    push_entry.taken      = fetch_taken_i;
    push_entry.exc[0]     = fetch_misaligned_instr_exc_i;
    push_entry.exc[12]    = fetch_instr_fault_exc_i;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (kill_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; stale entries are hidden by the empty mask below.
  always_ff @(posedge clk_i) begin
    if (push && !kill_i && !rst_i) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head = mem_q[rd_ptr_q];

  assign dec_instr_o      = dec_valid_o ? head.instr      : '0;
  assign dec_pc_o         = dec_valid_o ? head.pc         : '0;
  assign dec_pred_pc_o    = dec_valid_o ? head.pred_pc    : '0;
  assign dec_prediction_o = dec_valid_o ? head.prediction : 1'b0;
  assign dec_taken_o      = dec_valid_o ? head.taken      : 1'b0;
  assign dec_exc_bits_o   = dec_valid_o ? head.exc        : '0;

endmodule

// File: tb/tb_fetch_dec_queue.sv
// Self-checking bench for fetch_dec_queue: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_fetch_dec_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int EXC_W = 32;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             kill_i = 1'b0;
  logic             fetch_valid_i = 1'b0;
  logic             fetch_ready_o;
  logic [XLEN-1:0]  fetch_instr_i = '0;
  logic [XLEN-1:0]  fetch_pc_i = '0;
  logic [XLEN-1:0]  fetch_pred_pc_i = '0;
  logic             fetch_prediction_i = 1'b0;
  logic             fetch_taken_i = 1'b0;
  logic             fetch_misaligned_instr_exc_i = 1'b0;
  logic             fetch_instr_fault_exc_i = 1'b0;
  logic             dec_valid_o;
  logic             dec_ready_i = 1'b0;
  logic [XLEN-1:0]  dec_instr_o;
  logic [XLEN-1:0]  dec_pc_o;
  logic [XLEN-1:0]  dec_pred_pc_o;
  logic             dec_prediction_o;
  logic             dec_taken_o;
  logic [EXC_W-1:0] dec_exc_bits_o;
  logic [$clog2(DEPTH):0] count_o;

  fetch_dec_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .EXC_W(EXC_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .kill_i(kill_i),
    .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
    .fetch_instr_i(fetch_instr_i), .fetch_pc_i(fetch_pc_i),
    .fetch_pred_pc_i(fetch_pred_pc_i), .fetch_prediction_i(fetch_prediction_i),
    .fetch_taken_i(fetch_taken_i),
    .fetch_misaligned_instr_exc_i(fetch_misaligned_instr_exc_i),
    .fetch_instr_fault_exc_i(fetch_instr_fault_exc_i),
    .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
    .dec_instr_o(dec_instr_o), .dec_pc_o(dec_pc_o), .dec_pred_pc_o(dec_pred_pc_o),
    .dec_prediction_o(dec_prediction_o), .dec_taken_o(dec_taken_o),
    .dec_exc_bits_o(dec_exc_bits_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pred_pc;
    logic            prediction;
    logic            taken;
    logic            mis;
    logic            fault;
  } ent_t;

  ent_t model_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [EXC_W-1:0] exp_exc(input logic mis, input logic fault);
    logic [EXC_W-1:0] x;
    x     = '0;
    x[0]  = mis;
    x[12] = fault;
    return x;
  endfunction

  // Advance one clock; the model applies the spec's acceptance rules to the inputs
  // held across the edge, then outputs settle 1 time unit after the edge.
  task automatic tick();
    bit   do_push;
    bit   do_pop;
    ent_t e;
    do_push      = fetch_valid_i && (model_q.size() < DEPTH);
    do_pop       = dec_ready_i && (model_q.size() != 0);
    e.instr      = fetch_instr_i;
    e.pc         = fetch_pc_i;
    e.pred_pc    = fetch_pred_pc_i;
    e.prediction = fetch_prediction_i;
    e.taken      = fetch_taken_i;
    e.mis        = fetch_misaligned_instr_exc_i;
    e.fault      = fetch_instr_fault_exc_i;
    @(posedge clk_i);
    if (rst_i || kill_i) model_q.delete();
    else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(e);
    end
    #1;
  endtask

  task automatic set_fetch(input logic v, input logic [XLEN-1:0] pc,
                           input logic mis, input logic fault);
    fetch_valid_i                = v;
    fetch_pc_i                   = pc;
    fetch_instr_i                = pc ^ 32'h0000_0013;
    fetch_pred_pc_i              = pc + 32'd4;
    fetch_prediction_i           = pc[2];
    fetch_taken_i                = pc[3];
    fetch_misaligned_instr_exc_i = mis;
    fetch_instr_fault_exc_i      = fault;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    total++;
    if (count_o !== 0 || dec_valid_o !== 1'b0 || fetch_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_flags: count=%0d valid=%b ready=%b, want 0/0/1", count_o, dec_valid_o, fetch_ready_o);
    end
    total++;
    if ({dec_instr_o, dec_pc_o, dec_pred_pc_o, dec_prediction_o, dec_taken_o, dec_exc_bits_o} !== '0) begin
      bad++;
      $display("FAIL reset_data: instr=%h pc=%h pred=%h exc=%h, want all 0", dec_instr_o, dec_pc_o, dec_pred_pc_o, dec_exc_bits_o);
    end
  endtask

  task automatic test_single_push();
    fetch_valid_i = 1'b1;
    fetch_instr_i = 32'h0050_0093;
    fetch_pc_i = 32'h100;
    fetch_pred_pc_i = 32'h104;
    fetch_prediction_i = 1'b0;
    fetch_taken_i = 1'b0;
    fetch_misaligned_instr_exc_i = 1'b1;
    fetch_instr_fault_exc_i = 1'b0;
    dec_ready_i = 1'b0;
    total++;
    if (dec_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL single_no_bypass: valid=%b, want 0", dec_valid_o);
    end
    tick();
    fetch_valid_i = 1'b0;
    total++;
    if (dec_valid_o !== 1'b1 || dec_instr_o !== 32'h0050_0093 || dec_pc_o !== 32'h100 ||
        dec_pred_pc_o !== 32'h104 || dec_exc_bits_o !== 32'h1 || count_o !== 1) begin
      bad++;
      $display("FAIL single_push: valid=%b instr=%h pc=%h pred=%h exc=%h count=%0d, want 1/00500093/100/104/00000001/1",
               dec_valid_o, dec_instr_o, dec_pc_o, dec_pred_pc_o, dec_exc_bits_o, count_o);
    end
    dec_ready_i = 1'b1;
    tick();
    dec_ready_i = 1'b0;
    total++;
    if (count_o !== 0 || dec_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL single_drain: count=%0d valid=%b, want 0/0", count_o, dec_valid_o);
    end
  endtask

  task automatic test_full();
    dec_ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_fetch(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    total++;
    if (count_o !== DEPTH || fetch_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL full_flags: count=%0d ready=%b, want %0d/0", count_o, fetch_ready_o, DEPTH);
    end
    set_fetch(1'b1, 32'h110, 1'b0, 1'b0);
    tick();
    total++;
    if (count_o !== DEPTH || dec_pc_o !== 32'h100) begin
      bad++;
      $display("FAIL full_reject: count=%0d head_pc=%h, want %0d/100", count_o, dec_pc_o, DEPTH);
    end
    dec_ready_i = 1'b1;
    #1;
    total++;
    if (fetch_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL full_no_bypass: ready=%b, want 0", fetch_ready_o);
    end
    tick();
    fetch_valid_i = 1'b0;
    total++;
    if (count_o !== DEPTH - 1 || dec_pc_o !== 32'h104) begin
      bad++;
      $display("FAIL full_pop: count=%0d head_pc=%h, want %0d/104", count_o, dec_pc_o, DEPTH - 1);
    end
    for (int i = 1; i < DEPTH; i++) begin
      total++;
      if (dec_pc_o !== 32'h100 + 32'(4 * i)) begin
        bad++;
        $display("FAIL full_order: head_pc=%h, want %h", dec_pc_o, 32'h100 + 32'(4 * i));
      end
      tick();
    end
    dec_ready_i = 1'b0;
    total++;
    if (count_o !== 0 || dec_pc_o !== '0) begin
      bad++;
      $display("FAIL full_empty: count=%0d pc=%h, want 0/0", count_o, dec_pc_o);
    end
  endtask

  task automatic test_back_to_back();
    set_fetch(1'b1, 32'h200, 1'b0, 1'b0);
    dec_ready_i = 1'b0;
    tick();
    dec_ready_i = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      set_fetch(1'b1, 32'h200 + 32'(4 * k), 1'b0, 1'b0);
      total++;
      if (dec_pc_o !== 32'h200 + 32'(4 * (k - 1)) || count_o !== 1) begin
        bad++;
        $display("FAIL stream_k%0d: head_pc=%h count=%0d, want %h/1", k, dec_pc_o, count_o, 32'h200 + 32'(4 * (k - 1)));
      end
      tick();
    end
    fetch_valid_i = 1'b0;
    tick();
    dec_ready_i = 1'b0;
    total++;
    if (count_o !== 0) begin
      bad++;
      $display("FAIL stream_drain: count=%0d, want 0", count_o);
    end
  endtask

  task automatic test_kill();
    dec_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_fetch(1'b1, 32'h280 + 32'(4 * i), 1'b1, 1'b1);
      tick();
    end
    set_fetch(1'b1, 32'h300, 1'b0, 1'b0);
    kill_i = 1'b1;
    dec_ready_i = 1'b1;
    tick();
    kill_i = 1'b0;
    fetch_valid_i = 1'b0;
    total++;
    if (count_o !== 0 || dec_valid_o !== 1'b0 || dec_pc_o !== '0 || dec_exc_bits_o !== '0) begin
      bad++;
      $display("FAIL kill_flush: count=%0d valid=%b pc=%h exc=%h, want 0/0/0/0", count_o, dec_valid_o, dec_pc_o, dec_exc_bits_o);
    end
    tick();
    dec_ready_i = 1'b0;
    total++;
    if (dec_valid_o !== 1'b0 || dec_pc_o === 32'h300) begin
      bad++;
      $display("FAIL kill_discard: valid=%b pc=%h, want 0 and never 300", dec_valid_o, dec_pc_o);
    end
  endtask

  task automatic test_reset_kill();
    dec_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_fetch(1'b1, 32'h380 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    fetch_valid_i = 1'b0;
    rst_i = 1'b1;
    kill_i = 1'b1;
    tick();
    rst_i = 1'b0;
    kill_i = 1'b0;
    total++;
    if (count_o !== 0 || dec_valid_o !== 1'b0 || fetch_ready_o !== 1'b1 || dec_instr_o !== '0) begin
      bad++;
      $display("FAIL rstkill_state: count=%0d valid=%b ready=%b instr=%h, want 0/0/1/0", count_o, dec_valid_o, fetch_ready_o, dec_instr_o);
    end
    set_fetch(1'b1, 32'h400, 1'b0, 1'b1);
    tick();
    fetch_valid_i = 1'b0;
    total++;
    if (dec_valid_o !== 1'b1 || dec_exc_bits_o !== 32'h0000_1000) begin
      bad++;
      $display("FAIL fault_pack: valid=%b exc=%h, want 1/00001000", dec_valid_o, dec_exc_bits_o);
    end
    dec_ready_i = 1'b1;
    tick();
    dec_ready_i = 1'b0;
  endtask

  task automatic test_random();
    ent_t h;
    for (int c = 0; c < 400; c++) begin
      fetch_valid_i                = 1'($urandom_range(0, 3) != 0);
      fetch_instr_i                = $urandom;
      fetch_pc_i                   = $urandom;
      fetch_pred_pc_i              = $urandom;
      fetch_prediction_i           = 1'($urandom);
      fetch_taken_i                = 1'($urandom);
      fetch_misaligned_instr_exc_i = 1'($urandom);
      fetch_instr_fault_exc_i      = 1'($urandom);
      dec_ready_i                  = 1'($urandom_range(0, 2) != 0);
      kill_i                       = 1'($urandom_range(0, 31) == 0);
      rst_i                        = 1'($urandom_range(0, 63) == 0);
      total++;
      if (count_o !== model_q.size() || dec_valid_o !== (model_q.size() != 0) ||
          fetch_ready_o !== (model_q.size() < DEPTH)) begin
        bad++;
        $display("FAIL rand_flags c%0d: count=%0d valid=%b ready=%b, want count=%0d", c, count_o, dec_valid_o, fetch_ready_o, model_q.size());
      end
      total++;
      if (model_q.size() != 0) begin
        h = model_q[0];
        if (dec_instr_o !== h.instr || dec_pc_o !== h.pc || dec_pred_pc_o !== h.pred_pc ||
            dec_prediction_o !== h.prediction || dec_taken_o !== h.taken ||
            dec_exc_bits_o !== exp_exc(h.mis, h.fault)) begin
          bad++;
          $display("FAIL rand_head c%0d: instr=%h pc=%h exc=%h, want %h/%h/%h", c, dec_instr_o, dec_pc_o, dec_exc_bits_o,
                   h.instr, h.pc, exp_exc(h.mis, h.fault));
        end
      end else if ({dec_instr_o, dec_pc_o, dec_pred_pc_o, dec_prediction_o, dec_taken_o, dec_exc_bits_o} !== '0) begin
        bad++;
        $display("FAIL rand_bubble c%0d: instr=%h pc=%h exc=%h, want all 0", c, dec_instr_o, dec_pc_o, dec_exc_bits_o);
      end
      tick();
    end
    fetch_valid_i = 1'b0;
    dec_ready_i   = 1'b0;
    kill_i        = 1'b0;
    rst_i         = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_full();
    test_back_to_back();
    test_kill();
    test_reset_kill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
